// File: rtl/tx_engine.sv
// tx_engine: UART transmit engine. Pops one byte at a time from a TX FIFO and
// serialises it as start bit, eight data bits (LSB first) and a stop bit, each
// bit lasting OSR pulses of the external oversample strobe.
`timescale 1ns/1ps

module tx_engine #(
    parameter int OSR = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       osr_tick_i,
    input  logic       tx_fifo_empty_i,
    input  logic       tx_fifo_valid_i,
    input  logic [7:0] tx_fifo_data_i,
    output logic       tx_fifo_ren_o,
    input  logic       tx_en_i,
    output logic       tx_busy_o,
    output logic       transmit_bit_o
);

    localparam int CNT_W = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam logic [3:0] IDX_START = 4'd0;
    localparam logic [3:0] IDX_STOP  = 4'd9;
    localparam logic [3:0] IDX_END   = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] osr_cnt_q;
    logic [CNT_W-1:0] osr_cnt_d;
    logic             baud_tick_r;
    logic             baud_tick_d;
    logic [3:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             ren_q;
    logic             line_q;

    // Oversample counter: parked at zero outside SEND, wraps every OSR strobes
    // and flags the wrap so the bit boundary is seen one clock later.
    always_comb begin
        osr_cnt_d   = osr_cnt_q;
        baud_tick_d = 1'b0;
        if (state_q != SEND) begin
            osr_cnt_d = '0;
        end else if (osr_tick_i) begin
            if (osr_cnt_q == CNT_LAST) begin
                osr_cnt_d   = '0;
                baud_tick_d = 1'b1;
            end else begin
                osr_cnt_d = osr_cnt_q + 1'b1;
            end
        end
    end

    // Oversample counter and baud strobe registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            osr_cnt_q   <= '0;
            baud_tick_r <= 1'b0;
        end else begin
            osr_cnt_q   <= osr_cnt_d;
            baud_tick_r <= baud_tick_d;
        end
    end

    // Frame sequencer: fetch handshake, bit index, shift register and line.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            ren_q     <= 1'b0;
            line_q    <= 1'b1;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    line_q <= 1'b1;
                    if (tx_en_i && !tx_fifo_empty_i) begin
                        state_q <= FETCH;
                        ren_q   <= 1'b1;
                    end else begin
                        ren_q <= 1'b0;
                    end
                end
                FETCH: begin
                    // Only one pop request per frame; afterwards just wait for data.
                    ren_q <= 1'b0;
                    if (tx_fifo_valid_i) begin
                        shift_q   <= tx_fifo_data_i;
                        bit_idx_q <= IDX_START;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    ren_q <= 1'b0;
                    if (baud_tick_r) begin
                        if (bit_idx_q == IDX_END) begin
                            // End of the stop-bit period: line stays high.
                            line_q    <= 1'b1;
                            bit_idx_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            if (bit_idx_q == IDX_START) begin
                                line_q <= 1'b0;
                            end else if (bit_idx_q == IDX_STOP) begin
                                line_q <= 1'b1;
                            end else begin
                                line_q  <= shift_q[0];
                                shift_q <= {1'b0, shift_q[7:1]};
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                    line_q  <= 1'b1;
                end
            endcase
        end
    end

    assign tx_fifo_ren_o  = ren_q;
    assign tx_busy_o      = (state_q != IDLE);
    assign transmit_bit_o = line_q;

endmodule

// File: tb/tb_tx_engine.sv
// tb_tx_engine: randomized bench for tx_engine. A FIFO responder feeds bytes and
// records each issued byte in an expectation queue; an independent line monitor
// decodes the serial waveform by counting oversample strobes and checks it.
`timescale 1ns/1ps

module tb_tx_engine;

    localparam int OSR = 16;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       osr_tick_i = 1'b0;
    logic       tx_fifo_empty_i = 1'b1;
    logic       tx_fifo_valid_i = 1'b0;
    logic [7:0] tx_fifo_data_i = 8'h00;
    logic       tx_en_i = 1'b0;
    logic       tx_fifo_ren_o;
    logic       tx_busy_o;
    logic       transmit_bit_o;

    tx_engine #(.OSR(OSR)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .osr_tick_i      (osr_tick_i),
        .tx_fifo_empty_i (tx_fifo_empty_i),
        .tx_fifo_valid_i (tx_fifo_valid_i),
        .tx_fifo_data_i  (tx_fifo_data_i),
        .tx_fifo_ren_o   (tx_fifo_ren_o),
        .tx_en_i         (tx_en_i),
        .tx_busy_o       (tx_busy_o),
        .transmit_bit_o  (transmit_bit_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    bit rand_gap = 1'b0;
    int tgap;
    int ren_pulses = 0;
    int frames_done = 0;

    bit         mon_active = 1'b0;
    int         mon_ticks = 0;
    logic [9:0] mon_bits = '0;
    int         fall_wait = 0;
    bit         pre_arm = 1'b0;
    int         pre_ticks = 0;
    logic       prev_ren = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Oversample strobe: one clock wide, spaced 11 clocks or randomly 3..8 clocks.
    initial begin
        forever begin
            tgap = rand_gap ? int'($urandom_range(3, 8)) : 11;
            repeat (tgap - 1) @(posedge clk);
            #2 osr_tick_i = 1'b1;
            @(posedge clk);
            #2 osr_tick_i = 1'b0;
        end
    end

    // FIFO empty flag follows the bench FIFO contents.
    initial begin
        forever begin
            @(posedge clk);
            #2 tx_fifo_empty_i = (fifo_q.size() == 0);
        end
    end

    // FIFO read responder: pops on each read strobe, returns data after 1..3 clocks.
    initial begin
        logic [7:0] cur;
        int lat;
        forever begin
            @(negedge clk);
            if (reset_i && tx_fifo_ren_o) begin
                if (fifo_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ren_on_empty: read strobe with empty FIFO, required none (t=%0t)", $time);
                end else begin
                    cur = fifo_q.pop_front();
                    exp_q.push_back(cur);
                    lat = (frames_done == 0) ? 0 : int'($urandom_range(0, 2));
                    repeat (lat) @(posedge clk);
                    @(posedge clk);
                    #2 tx_fifo_valid_i = 1'b1;
                    tx_fifo_data_i = cur;
                    @(posedge clk);
                    #2 tx_fifo_valid_i = 1'b0;
                    tx_fifo_data_i = 8'($urandom);
                end
            end
        end
    end

    // Line monitor: decodes frames by strobe counting and scores them against exp_q.
    always @(negedge clk) begin
        if (!reset_i) begin
            check("rst_line", 32'(transmit_bit_o), 32'd1);
            check("rst_busy", 32'(tx_busy_o), 32'd0);
            check("rst_ren", 32'(tx_fifo_ren_o), 32'd0);
            mon_active = 1'b0;
            fall_wait = 0;
            pre_arm = 1'b0;
            prev_ren = 1'b0;
            exp_q.delete();
        end else begin
            if (tx_fifo_ren_o) begin
                check("ren_single_cycle", 32'(prev_ren), 32'd0);
                check("ren_while_busy", 32'(tx_busy_o), 32'd1);
                ren_pulses++;
            end
            prev_ren = tx_fifo_ren_o;

            if (tx_fifo_valid_i) begin
                pre_arm = 1'b1;
                pre_ticks = 0;
            end else if (pre_arm && osr_tick_i) begin
                pre_ticks++;
            end

            if (fall_wait == 2) begin
                check("busy_fall", 32'(tx_busy_o), 32'd0);
                check("line_idle_after_frame", 32'(transmit_bit_o), 32'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: decoded %0h, none expected", mon_bits);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("frame_bits", 32'(mon_bits), 32'({1'b1, e, 1'b0}));
                end
                frames_done++;
                fall_wait = 0;
            end else if (fall_wait == 1) begin
                check("busy_in_last_cycle", 32'(tx_busy_o), 32'd1);
                fall_wait = 2;
            end

            if (!mon_active) begin
                if (transmit_bit_o == 1'b0) begin
                    mon_active = 1'b1;
                    mon_ticks = 0;
                    check("start_while_busy", 32'(tx_busy_o), 32'd1);
                    check("ticks_before_start", 32'(pre_ticks), 32'(OSR));
                    pre_arm = 1'b0;
                end
            end else if (osr_tick_i) begin
                mon_ticks++;
                if (mon_ticks % OSR == OSR / 2)
                    mon_bits[mon_ticks / OSR] = transmit_bit_o;
                if (mon_ticks == 10 * OSR) begin
                    check("busy_at_stop_end", 32'(tx_busy_o), 32'd1);
                    mon_active = 1'b0;
                    fall_wait = 1;
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 5 && n < 30000) begin
            @(negedge clk);
            n++;
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !tx_busy_o && !mon_active && fall_wait == 0)
                quiet++;
            else
                quiet = 0;
        end
        tests++;
        if (quiet < 5) begin
            fails++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    initial begin
        int n;
        int busy_seen;
        int ren_seen;
        int ren_before;

        // Reset held for 5 clocks with the transmitter disabled.
        #1 reset_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_i = 1'b1;
        @(negedge clk);
        check("post_rst_line", 32'(transmit_bit_o), 32'd1);
        check("post_rst_busy", 32'(tx_busy_o), 32'd0);

        // Frame 0xAA: exact fetch handshake timing, then 0x55 back-to-back.
        @(posedge clk);
        #2 tx_en_i = 1'b1;
        fifo_q.push_back(8'hAA);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_fifo_empty_i && n < 20);
        check("empty_dropped", 32'(tx_fifo_empty_i), 32'd0);
        @(negedge clk);
        check("fetch_ren_high", 32'(tx_fifo_ren_o), 32'd1);
        check("fetch_busy_high", 32'(tx_busy_o), 32'd1);
        @(negedge clk);
        check("fetch_ren_low", 32'(tx_fifo_ren_o), 32'd0);
        check("fetch_busy_hold", 32'(tx_busy_o), 32'd1);
        fifo_q.push_back(8'h55);
        wait_idle("aa55");
        check("frames_aa55", 32'(frames_done), 32'd2);
        check("ren_count_aa55", 32'(ren_pulses), 32'd2);

        // Enable low with data waiting: nothing may start.
        @(posedge clk);
        #2 tx_en_i = 1'b0;
        fifo_q.push_back(8'h0F);
        ren_before = ren_pulses;
        busy_seen = 0;
        ren_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_busy_o) busy_seen++;
            if (tx_fifo_ren_o) ren_seen++;
        end
        check("disabled_busy_cycles", 32'(busy_seen), 32'd0);
        check("disabled_ren_cycles", 32'(ren_seen), 32'd0);
        check("disabled_ren_count", 32'(ren_pulses), 32'(ren_before));

        // Enable, then drop enable mid-frame: the frame must still complete.
        @(posedge clk);
        #2 tx_en_i = 1'b1;
        n = 0;
        while (!(mon_active && mon_ticks > 2 * OSR) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        #2 tx_en_i = 1'b0;
        wait_idle("en_drop");
        check("frames_en_drop", 32'(frames_done), 32'd3);

        // Random bytes at random spacing with jittered oversample strobes.
        rand_gap = 1'b1;
        @(posedge clk);
        #2 tx_en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fifo_q.push_back(8'($urandom));
            repeat ($urandom_range(0, 400)) @(posedge clk);
            #2;
        end
        wait_idle("random");
        check("frames_random", 32'(frames_done), 32'd9);
        check("ren_count_random", 32'(ren_pulses), 32'd9);

        // Reset during data bit D3, then a clean frame afterwards.
        fifo_q.push_back(8'hC3);
        n = 0;
        while (!(mon_active && mon_ticks >= 4 * OSR + 4) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reached_d3", 32'(mon_active), 32'd1);
        @(negedge clk);
        #2 reset_i = 1'b0;
        #1;
        check("async_rst_line", 32'(transmit_bit_o), 32'd1);
        check("async_rst_busy", 32'(tx_busy_o), 32'd0);
        check("async_rst_ren", 32'(tx_fifo_ren_o), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset_i = 1'b1;
        @(negedge clk);
        check("after_rst_line", 32'(transmit_bit_o), 32'd1);
        check("after_rst_busy", 32'(tx_busy_o), 32'd0);
        fifo_q.push_back(8'h3C);
        wait_idle("after_rst");
        check("frames_after_rst", 32'(frames_done), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_engine.md
TX_ENGINE -- requirements
Module: tx_engine

Interface
REQ-001 Parameter OSR, default 16: number of osr_tick_i pulses per baud (bit) period; SHALL be >= 2.
REQ-002 clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  reset, asynchronous and active-low.
REQ-004 osr_tick_i  input  1  one-clk-wide oversample strobe from the baud generator.
REQ-005 tx_fifo_empty_i  input  1  TX FIFO empty flag; 1 = no data available.
REQ-006 tx_fifo_valid_i  input  1  TX FIFO read data valid; qualifies tx_fifo_data_i.
REQ-007 tx_fifo_data_i  input  8  TX FIFO read data byte.
REQ-008 tx_fifo_ren_o  output  1  TX FIFO read enable (one-clk pop request).
REQ-009 tx_en_i  input  1  transmitter enable.
REQ-010 tx_busy_o  output  1  1 while a frame is being fetched or sent.
REQ-011 transmit_bit_o  output  1  serial UART line; idle high.

Function
REQ-012 FSM states SHALL be IDLE, FETCH, SEND; tx_busy_o = (state != IDLE).
REQ-013 IDLE -> FETCH on a clk edge where tx_en_i=1 and tx_fifo_empty_i=0; otherwise stay IDLE.
REQ-014 tx_fifo_ren_o SHALL be registered and high for exactly the first clk cycle spent in FETCH, low at all other times.
REQ-015 In FETCH, on a clk edge with tx_fifo_valid_i=1, the engine SHALL latch tx_fifo_data_i into an 8-bit shift/hold register and move to SEND; otherwise stay in FETCH (no further ren pulses).
REQ-016 Internal oversample counter (width clog2(OSR)) SHALL be held at 0 outside SEND and SHALL count osr_tick_i pulses inside SEND.
REQ-017 Internal register baud_tick_r SHALL be high for one clk in the cycle after the OSR-th counted osr_tick_i (counter at OSR-1 and osr_tick_i=1 -> counter wraps to 0, baud_tick_r<=1); else 0.
REQ-018 Internal bit index 0..10 SHALL reset to 0 on SEND entry and increment on each baud_tick_r.
REQ-019 On each baud_tick_r in SEND, transmit_bit_o SHALL register: index 0 -> 0 (start bit), indices 1..8 -> data bits D0..D7 (LSB first), index 9 -> 1 (stop bit).
REQ-020 On the baud_tick_r at index 10 (end of stop-bit period), transmit_bit_o stays 1 and FSM SHALL return to IDLE (tx_busy_o low next cycle).
REQ-021 transmit_bit_o SHALL be 1 in IDLE, FETCH and in SEND before the first baud_tick_r.
REQ-022 Deasserting tx_en_i mid-frame SHALL NOT abort the frame; it only blocks starting the next frame from IDLE.
REQ-023 Back-to-back frames: from IDLE, a new frame may start the cycle after return to IDLE if tx_en_i=1 and FIFO not empty.
REQ-024 Frame duration from SEND entry to IDLE = 11 baud periods; each baud period = OSR osr_tick_i pulses.

Reset
REQ-025 While reset_i=0 (asynchronously): state=IDLE, tx_busy_o=0, tx_fifo_ren_o=0, transmit_bit_o=1, baud_tick_r=0, counters and data register cleared.
REQ-026 Reset asserted mid-frame SHALL abort immediately; after release engine is in IDLE with line high.

Verification
REQ-027 Reset held 5 clks, tx_en_i=0, empty=1 -> busy=0, ren=0, transmit_bit_o=1 throughout.
REQ-028 tx_en_i=1, empty 1->0 -> one clk later busy=1, ren=1; valid=1 with data 0xAA -> next clk ren=0, state SEND.
REQ-029 Frame 0xAA, OSR=16, osr_tick every 11 clks -> after each 16 ticks baud_tick_r=1; line sequence 0,0,1,0,1,0,1,0,1,1 (start, LSB-first data, stop); busy falls after stop period.
REQ-030 Second frame 0x55 immediately after -> line 0,1,0,1,0,1,0,1,0,1; no extra ren pulses.
REQ-031 tx_en_i=0 with empty=0 -> stays IDLE, ren never asserted; tx_en_i dropped mid-frame -> frame completes.
REQ-032 reset_i low during data bit 3 -> outputs immediately at reset values; after release new frame starts cleanly.
